// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the RV32I pipeline hazard controller.
//   Contents:
//     - RV32I major opcode constants (OP_*)
//     - forwarding select type and encodings (FWD_*)
//     - controller state type ctrl_state_t {RUN, MDU_BUSY}
//     - fwd_pick(): priority forwarding compare for one source operand
//     - op_writes_rd(): opcode classification used by decode-side helpers
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // EX operand mux selects.
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REG   = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  // Controller sequencing state.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } ctrl_state_t;

  // Forwarding choice for a single source register. The younger producer
  // (EX/MEM) has priority over MEM/WB because it holds the newer value.
  // x0 is hardwired to zero, so a write to it never supplies a bypass.
  function automatic fwd_sel_t fwd_pick(
    input logic [4:0] src,
    input logic [4:0] exMemRd,
    input logic       exMemWr,
    input logic [4:0] memWbRd,
    input logic       memWbWr
  );
    if (exMemWr && (exMemRd != 5'd0) && (exMemRd == src)) begin
      return FWD_EXMEM;
    end else if (memWbWr && (memWbRd != 5'd0) && (memWbRd == src)) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

  // True for opcodes whose instruction writes a destination register.
  function automatic logic op_writes_rd(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      OP_STORE, OP_BRANCH:                                    return 1'b0;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
//   Purely combinational EX-stage forwarding compare. Produces the operand
//   select for both ALU inputs from the source registers of the instruction
//   in EX and the destination/write-enable of the instructions in MEM and WB.
//   Ports:
//     ex_rs1_i, ex_rs2_i    in  5  source registers of the EX instruction
//     ex_mem_rd_i           in  5  destination of the MEM instruction
//     ex_mem_wr_i           in  1  MEM instruction writes its rd
//     mem_wb_rd_i           in  5  destination of the WB instruction
//     mem_wb_wr_i           in  1  WB instruction writes its rd
//     fwd_a_sel_o           out 2  select for operand A (rs1)
//     fwd_b_sel_o           out 2  select for operand B (rs2)
// ---------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module fwd_unit (
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] ex_mem_rd_i,
  input  logic       ex_mem_wr_i,
  input  logic [4:0] mem_wb_rd_i,
  input  logic       mem_wb_wr_i,
  output fwd_sel_t   fwd_a_sel_o,
  output fwd_sel_t   fwd_b_sel_o
);

  // Both operands use the same priority rule; only the source differs.
  always_comb begin
    fwd_a_sel_o = fwd_pick(ex_rs1_i, ex_mem_rd_i, ex_mem_wr_i,
                           mem_wb_rd_i, mem_wb_wr_i);
    fwd_b_sel_o = fwd_pick(ex_rs2_i, ex_mem_rd_i, ex_mem_wr_i,
                           mem_wb_rd_i, mem_wb_wr_i);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central hazard controller of the 5-stage RV32I pipeline. Decides each
//   cycle how EX is fed (forwarding), whether the front end must stall
//   (load-use, multi-cycle MDU), whether IF/ID and ID/EX are squashed
//   (taken branch/jump), and keeps saturating hazard statistics.
//   Parameters:
//     MDU_TIMEOUT  busy cycles allowed before an MDU op is aborted (>= 2)
//     CNT_W        width of the saturating statistics counters
//   Ports:
//     clk, rst_n                      clock / synchronous active-low reset
//     id_rs1, id_rs2, id_uses_rs1/2   sources of the ID instruction
//     id_ex_rs1, id_ex_rs2, id_ex_rd  registers of the EX instruction
//     id_ex_mem_read_en               EX instruction is a load
//     ex_mem_rd, ex_mem_reg_write_en  MEM destination / write enable
//     mem_wb_rd, mem_wb_reg_write_en  WB destination / write enable
//     branch_taken                    EX resolved a taken branch/jump
//     mdu_start, mdu_done             MDU op entry pulse / result valid
//     fwd_a_sel, fwd_b_sel            00 regfile, 01 EX/MEM, 10 MEM/WB
//     pc_stall, if_id_stall           hold PC and IF/ID
//     id_ex_stall, id_ex_bubble       hold ID/EX / load NOP into ID/EX
//     ex_mem_bubble                   load NOP into EX/MEM
//     if_id_flush, id_ex_flush        squash IF/ID and ID/EX
//     mdu_timeout                     sticky MDU abort flag
//     stall_cycles, flush_events      saturating statistics
// ---------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read_en,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_reg_write_en,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_reg_write_en,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned BUSY_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MDU_TIMEOUT - 1);

  ctrl_state_t       state_q, state_d;
  logic [BUSY_W-1:0] busyCnt_q, busyCnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

  logic inRun;
  logic rawLoadUse;
  logic mduStall;
  logic loadUse;
  logic flush;
  logic frontStall;

  fwd_sel_t fwdA;
  fwd_sel_t fwdB;

  // Operand bypass selection lives in its own block so the compare network
  // stays separate from the sequencing logic.
  fwd_unit u_fwd (
    .ex_rs1_i    (id_ex_rs1),
    .ex_rs2_i    (id_ex_rs2),
    .ex_mem_rd_i (ex_mem_rd),
    .ex_mem_wr_i (ex_mem_reg_write_en),
    .mem_wb_rd_i (mem_wb_rd),
    .mem_wb_wr_i (mem_wb_reg_write_en),
    .fwd_a_sel_o (fwdA),
    .fwd_b_sel_o (fwdB)
  );

  // Hazard classification for the current cycle. An MDU op stalls the
  // front end from the cycle it enters EX (mdu_start) until the cycle its
  // result appears; the done cycle itself is not stalled. A load-use hazard
  // is only meaningful in RUN, and a taken branch wins over it because the
  // dependent instruction in ID is being squashed anyway. The MDU entry
  // cycle already holds ID/EX, so a bubble is never requested on top of it.
  always_comb begin
    inRun      = (state_q == RUN);
    rawLoadUse = id_ex_mem_read_en && (id_ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == id_ex_rd)));
    mduStall   = inRun ? (mdu_start && !mdu_done) : !mdu_done;
    flush      = inRun && branch_taken;
    loadUse    = inRun && rawLoadUse && !flush && !mduStall;
    frontStall = loadUse || mduStall;
  end

  // MDU sequencing. Entering MDU_BUSY loads the busy counter with 1, so the
  // counter equals the number of stalled cycles spent on the op so far. When
  // the next increment would reach MDU_TIMEOUT without a done, the op is
  // abandoned, the sticky flag is raised and the pipeline resumes.
  always_comb begin
    state_d   = state_q;
    busyCnt_d = busyCnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (mdu_start && !mdu_done) begin
          state_d   = MDU_BUSY;
          busyCnt_d = BUSY_W'(1);
        end
      end
      MDU_BUSY: begin
        if (mdu_done) begin
          state_d   = RUN;
          busyCnt_d = '0;
        end else if (busyCnt_q == BUSY_LAST) begin
          state_d   = RUN;
          busyCnt_d = '0;
          timeout_d = 1'b1;
        end else begin
          busyCnt_d = busyCnt_q + BUSY_W'(1);
        end
      end
      default: begin
        state_d   = RUN;
        busyCnt_d = '0;
      end
    endcase
  end

  // Statistics counters stop at all-ones so a long run never reports a
  // small, wrapped-around value.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (frontStall && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    if (flush && (flushCnt_q != {CNT_W{1'b1}})) begin
      flushCnt_d = flushCnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset abandons any MDU op in flight without flagging a
  // timeout and clears the statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      busyCnt_q  <= '0;
      timeout_q  <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busyCnt_q  <= busyCnt_d;
      timeout_q  <= timeout_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // Output drive. During an MDU op the instruction in EX is held in ID/EX
  // and EX/MEM receives NOPs; during load-use the ID instruction is held
  // and a NOP is inserted into ID/EX instead.
  always_comb begin
    fwd_a_sel     = fwdA;
    fwd_b_sel     = fwdB;
    pc_stall      = frontStall;
    if_id_stall   = frontStall;
    id_ex_stall   = mduStall;
    id_ex_bubble  = loadUse;
    ex_mem_bubble = mduStall;
    if_id_flush   = flush;
    id_ex_flush   = flush;
    mdu_timeout   = timeout_q;
    stall_cycles  = stallCnt_q;
    flush_events  = flushCnt_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Two instances share all inputs: the
//   default configuration and one with 4-bit statistics counters so that
//   saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       usesRs1;
    logic       usesRs2;
    logic [4:0] exRs1;
    logic [4:0] exRs2;
    logic [4:0] exRd;
    logic       exMemRead;
    logic [4:0] memRd;
    logic       memWr;
    logic [4:0] wbRd;
    logic       wbWr;
    logic       branch;
    logic       mduStart;
    logic       mduDone;
  } stim_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic        id_uses_rs1, id_uses_rs2, id_ex_mem_read_en;
  logic        ex_mem_reg_write_en, mem_wb_reg_write_en;
  logic        branch_taken, mdu_start, mdu_done;

  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_stall, if_id_stall, id_ex_stall, id_ex_bubble;
  logic        ex_mem_bubble, if_id_flush, id_ex_flush, mdu_timeout;
  logic [15:0] stall_cycles, flush_events;

  logic [1:0]  fwdASmall, fwdBSmall;
  logic        pcStallSmall, ifIdStallSmall, idExStallSmall, idExBubbleSmall;
  logic        exMemBubbleSmall, ifIdFlushSmall, idExFlushSmall, timeoutSmall;
  logic [3:0]  stallCyclesSmall, flushEventsSmall;

  int checks = 0;
  int fails  = 0;
  stim_t s;
  int stallSeen;

  pipe_hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read_en(id_ex_mem_read_en),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write_en(ex_mem_reg_write_en),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write_en(mem_wb_reg_write_en),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mdu_timeout(mdu_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipe_hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read_en(id_ex_mem_read_en),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write_en(ex_mem_reg_write_en),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write_en(mem_wb_reg_write_en),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .fwd_a_sel(fwdASmall), .fwd_b_sel(fwdBSmall),
    .pc_stall(pcStallSmall), .if_id_stall(ifIdStallSmall),
    .id_ex_stall(idExStallSmall), .id_ex_bubble(idExBubbleSmall),
    .ex_mem_bubble(exMemBubbleSmall),
    .if_id_flush(ifIdFlushSmall), .id_ex_flush(idExFlushSmall),
    .mdu_timeout(timeoutSmall),
    .stall_cycles(stallCyclesSmall), .flush_events(flushEventsSmall)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs on the falling edge, then settle before sampling.
  task automatic applyStimulus(input stim_t v);
    @(negedge clk);
    id_rs1              = v.rs1;
    id_rs2              = v.rs2;
    id_uses_rs1         = v.usesRs1;
    id_uses_rs2         = v.usesRs2;
    id_ex_rs1           = v.exRs1;
    id_ex_rs2           = v.exRs2;
    id_ex_rd            = v.exRd;
    id_ex_mem_read_en   = v.exMemRead;
    ex_mem_rd           = v.memRd;
    ex_mem_reg_write_en = v.memWr;
    mem_wb_rd           = v.wbRd;
    mem_wb_reg_write_en = v.wbWr;
    branch_taken        = v.branch;
    mdu_start           = v.mduStart;
    mdu_done            = v.mduDone;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One reset cycle with idle inputs, released on the next falling edge.
  task automatic resetDut();
    applyStimulus('0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus('0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_fwd_a", 32'(fwd_a_sel), 0);
    checkOutput("rst_pc_stall", 32'(pc_stall), 0);
    checkOutput("rst_timeout", 32'(mdu_timeout), 0);
    checkOutput("rst_stall_cycles", 32'(stall_cycles), 0);
    checkOutput("rst_flush_events", 32'(flush_events), 0);

    $display("[TB] forwarding");
    s = '0; s.memRd = 5; s.memWr = 1; s.wbRd = 5; s.wbWr = 1; s.exRs1 = 5;
    applyStimulus(s);
    checkOutput("fwd_both_match_a", 32'(fwd_a_sel), 1);
    checkOutput("fwd_both_match_b", 32'(fwd_b_sel), 0);
    s = '0; s.memWr = 1; s.wbWr = 1;
    applyStimulus(s);
    checkOutput("fwd_x0_a", 32'(fwd_a_sel), 0);
    s = '0; s.memRd = 3; s.memWr = 1; s.wbRd = 6; s.wbWr = 1;
    s.exRs1 = 3; s.exRs2 = 6;
    applyStimulus(s);
    checkOutput("fwd_split_a", 32'(fwd_a_sel), 1);
    checkOutput("fwd_split_b", 32'(fwd_b_sel), 2);
    s = '0; s.memRd = 6; s.memWr = 0; s.wbRd = 6; s.wbWr = 1; s.exRs2 = 6;
    applyStimulus(s);
    checkOutput("fwd_exmem_nowr_b", 32'(fwd_b_sel), 2);
    s.wbWr = 0;
    applyStimulus(s);
    checkOutput("fwd_none_b", 32'(fwd_b_sel), 0);

    $display("[TB] load-use");
    s = '0; s.exMemRead = 1; s.exRd = 7; s.rs2 = 7; s.usesRs2 = 0;
    applyStimulus(s);
    checkOutput("lu_unused_src", 32'(pc_stall), 0);
    s = '0; s.exMemRead = 1; s.usesRs1 = 1;
    applyStimulus(s);
    checkOutput("lu_x0", 32'(pc_stall), 0);
    s = '0; s.exMemRead = 1; s.exRd = 7; s.rs2 = 7; s.usesRs2 = 1;
    applyStimulus(s);
    checkOutput("lu_pc_stall", 32'(pc_stall), 1);
    checkOutput("lu_if_id_stall", 32'(if_id_stall), 1);
    checkOutput("lu_id_ex_bubble", 32'(id_ex_bubble), 1);
    checkOutput("lu_id_ex_stall", 32'(id_ex_stall), 0);
    checkOutput("lu_ex_mem_bubble", 32'(ex_mem_bubble), 0);
    s = '0; s.memRd = 7; s.memWr = 1;
    applyStimulus(s);
    checkOutput("lu_next_pc_stall", 32'(pc_stall), 0);
    checkOutput("lu_next_bubble", 32'(id_ex_bubble), 0);
    checkOutput("lu_stall_cycles", 32'(stall_cycles), 1);

    $display("[TB] load-use with taken branch");
    s = '0; s.exMemRead = 1; s.exRd = 7; s.rs2 = 7; s.usesRs2 = 1; s.branch = 1;
    applyStimulus(s);
    checkOutput("br_if_id_flush", 32'(if_id_flush), 1);
    checkOutput("br_id_ex_flush", 32'(id_ex_flush), 1);
    checkOutput("br_pc_stall", 32'(pc_stall), 0);
    checkOutput("br_bubble", 32'(id_ex_bubble), 0);
    applyStimulus('0);
    checkOutput("br_flush_events", 32'(flush_events), 1);
    checkOutput("br_stall_cycles", 32'(stall_cycles), 1);

    $display("[TB] single-cycle MDU op");
    s = '0; s.mduStart = 1; s.mduDone = 1;
    applyStimulus(s);
    checkOutput("mdu1_stall", 32'(pc_stall), 0);
    applyStimulus('0);
    checkOutput("mdu1_after", 32'(pc_stall), 0);

    $display("[TB] four-cycle MDU op");
    for (int k = 0; k < 5; k++) begin
      s = '0;
      s.mduStart = (k == 0);
      s.mduDone  = (k == 4);
      if (k == 2) s.branch = 1;
      if (k == 3) begin
        s.exMemRead = 1; s.exRd = 9; s.rs1 = 9; s.usesRs1 = 1;
      end
      applyStimulus(s);
      checkOutput($sformatf("mdu4_pc_stall_%0d", k), 32'(pc_stall), 32'(k < 4));
      checkOutput($sformatf("mdu4_id_ex_stall_%0d", k), 32'(id_ex_stall), 32'(k < 4));
      checkOutput($sformatf("mdu4_ex_mem_bubble_%0d", k), 32'(ex_mem_bubble), 32'(k < 4));
      checkOutput($sformatf("mdu4_flush_%0d", k), 32'(if_id_flush), 0);
      checkOutput($sformatf("mdu4_id_ex_bubble_%0d", k), 32'(id_ex_bubble), 0);
    end
    applyStimulus('0);
    checkOutput("mdu4_after", 32'(pc_stall), 0);
    checkOutput("mdu4_stall_cycles", 32'(stall_cycles), 5);
    checkOutput("mdu4_flush_events", 32'(flush_events), 1);

    $display("[TB] MDU timeout");
    stallSeen = 0;
    for (int c = 0; c < 100; c++) begin
      s = '0;
      s.mduStart = (c == 0);
      applyStimulus(s);
      if (pc_stall) stallSeen++;
      else break;
    end
    checkOutput("to_stall_len", 32'(stallSeen), 64);
    checkOutput("to_flag", 32'(mdu_timeout), 1);
    applyStimulus('0);
    checkOutput("to_sticky", 32'(mdu_timeout), 1);
    checkOutput("to_no_stall", 32'(pc_stall), 0);
    checkOutput("to_stall_cycles", 32'(stall_cycles), 69);
    checkOutput("to_small_flag", 32'(timeoutSmall), 1);
    checkOutput("sat_small_stall", 32'(stallCyclesSmall), 15);
    resetDut();
    checkOutput("to_rst_flag", 32'(mdu_timeout), 0);
    checkOutput("to_rst_stall_cycles", 32'(stall_cycles), 0);
    checkOutput("to_rst_small_stall", 32'(stallCyclesSmall), 0);

    $display("[TB] reset during MDU op");
    s = '0; s.mduStart = 1;
    applyStimulus(s);
    applyStimulus('0);
    checkOutput("mr_busy1", 32'(pc_stall), 1);
    resetDut();
    checkOutput("mr_pc_stall", 32'(pc_stall), 0);
    checkOutput("mr_id_ex_stall", 32'(id_ex_stall), 0);
    checkOutput("mr_ex_mem_bubble", 32'(ex_mem_bubble), 0);
    checkOutput("mr_timeout", 32'(mdu_timeout), 0);
    checkOutput("mr_stall_cycles", 32'(stall_cycles), 0);
    checkOutput("mr_fwd_a", 32'(fwd_a_sel), 0);
    applyStimulus('0);
    checkOutput("mr_run_state", 32'(pc_stall), 0);

    $display("[TB] flush counter saturation");
    for (int k = 0; k < 20; k++) begin
      s = '0; s.branch = 1;
      applyStimulus(s);
    end
    applyStimulus('0);
    checkOutput("sat_big_flush", 32'(flush_events), 20);
    checkOutput("sat_small_flush", 32'(flushEventsSmall), 15);
    checkOutput("sat_big_stall", 32'(stall_cycles), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
